ring_xbar3_switch_alloc: RTL
============================

Name: ring_xbar3_switch_alloc

Overview:
Switch allocator and sequencer for the 3x3 router crossbar in the ring network. It takes per-input requests (valid, destination output, tail flag) and arbitrates each output among up to three contending inputs with per-output round-robin priority. It holds a grant for the full duration of a multi-flit packet and drives the crossbar's three 2-bit mux selects plus the val/rdy handshakes on both sides. All state and outputs carry the security label of the single `domain` input.

Parameters:
p_ninputs, 3, number of input/output ports; fixed at 3 because the select encoding is 2 bits.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
domain  input  1  security domain of this router instance; label {L}; all other ports {Domain domain}
in0_val, in1_val, in2_val  input  1 each  input i has a flit present
in0_dest, in1_dest, in2_dest  input  2 each  requested output 0..2; value 3 is invalid
in0_tail, in1_tail, in2_tail  input  1 each  current flit is the last flit of its packet
in0_rdy, in1_rdy, in2_rdy  output  1 each  flit on input i is accepted this cycle
out0_val, out1_val, out2_val  output  1 each  output j carries a valid flit
out0_rdy, out1_rdy, out2_rdy  input  1 each  downstream accepts output j
sel0, sel1, sel2  output  2 each  crossbar mux select for output j; value = index of the granted input

Behaviour:
- Per-output state: mode (IDLE/LOCKED), owner[1:0], prio[1:0] (next input to favour).
- Reset: all modes IDLE, owner=0, prio=0. Outputs during reset: all out_val=0, in_rdy=0, sel=0. Reset mid-packet drops every lock.
- A request of input i to output j exists when in_i_val=1 and in_i_dest=j. dest=3 never requests; in_rdy for that input is 0.
- IDLE grant is combinational, with zero-cycle latency: scan inputs prio, prio+1, prio+2 (mod 3) and take the first one with a request to j. If a grant exists: sel_j=grantee and out_j_val=1. If no grant: out_j_val=0 and sel_j holds its last registered value (0 after reset).
- LOCKED: grant is forced to owner and sel_j=owner. out_j_val = in_owner_val. Other inputs targeting j see in_rdy=0. The sender must keep dest constant within a packet. While locked, dest is not rechecked.
- in_i_rdy = 1 iff input i is the current grantee of output in_i_dest and out_rdy of that output is 1. Transfer on output j is out_j_val & out_j_rdy, which is identical to the grantee's val & rdy.
- State update at posedge clk for each output j:
  - Transfer of a non-tail flit while IDLE: enter LOCKED, owner=grantee.
  - Transfer of a tail flit in either mode: go to IDLE, prio=(grantee+1) mod 3.
  - Transfer of a non-tail flit while LOCKED: no change.
  - No transfer: no change, so the grant does not move while out_rdy=0. In IDLE, though, the combinational grant may change if requests change.
- A single-flit packet (tail=1 on first flit) never locks; prio still advances.
- Outputs are independent. Each input names one dest, so an input is granted by at most one output per cycle. All three outputs may transfer in the same cycle.
- sel is a registered-hold select: the last granted index is stored at each transfer so the crossbar input stays stable while the output is idle.

Test Plan:
- Reset then idle: assert reset 2 cycles with all val=1, dest=0 -> out*_val=0, in*_rdy=0, sel*=0 during reset. First cycle after reset: out0_val=1, sel0=0, in0_rdy=1 (out0_rdy=1).
- Round-robin: in0/in1/in2 all val, dest=1, tail=1, out1_rdy=1 for 3 cycles -> sel1 sequence 0,1,2, one in_rdy high per cycle. Fourth cycle -> sel1=0.
- Packet lock: in2 sends 3 flits to out0 (tail on third) while in0 also requests out0 -> sel0=2 for 3 transfers, in0_rdy=0 throughout. Next cycle sel0=0, in0_rdy=1.
- Backpressure: lock in1 to out2, drop out2_rdy for 4 cycles -> in1_rdy=0, out2_val=1, sel2=1 stable. Grant does not move; transfer resumes when rdy returns.
- Parallel/invalid: in0->out2, in1->out0, in2->out1 with all rdy -> three simultaneous transfers, sel0=1, sel1=2, sel2=0. Then in1_dest=3 -> in1_rdy=0, out0_val=0.
- Reset mid-packet: reset during in0 lock on out1 -> after reset out1 IDLE, prio=0. A pending in2 request to out1 is granted immediately.

Source files
------------

// File: rtl/ring_xbar3_switch_alloc_if.sv
// Handshake and select bundle between the ring router ports and its 3x3 switch allocator.
// master drives flits and downstream readiness; slave is the allocator.
interface ring_xbar3_switch_alloc_if;
    logic       in0_val, in1_val, in2_val;
    logic [1:0] in0_dest, in1_dest, in2_dest;
    logic       in0_tail, in1_tail, in2_tail;
    logic       in0_rdy, in1_rdy, in2_rdy;
    logic       out0_val, out1_val, out2_val;
    logic       out0_rdy, out1_rdy, out2_rdy;
    logic [1:0] sel0, sel1, sel2;

    modport master (
        output in0_val, in1_val, in2_val,
        output in0_dest, in1_dest, in2_dest,
        output in0_tail, in1_tail, in2_tail,
        output out0_rdy, out1_rdy, out2_rdy,
        input  in0_rdy, in1_rdy, in2_rdy,
        input  out0_val, out1_val, out2_val,
        input  sel0, sel1, sel2
    );

    modport slave (
        input  in0_val, in1_val, in2_val,
        input  in0_dest, in1_dest, in2_dest,
        input  in0_tail, in1_tail, in2_tail,
        input  out0_rdy, out1_rdy, out2_rdy,
        output in0_rdy, in1_rdy, in2_rdy,
        output out0_val, out1_val, out2_val,
        output sel0, sel1, sel2
    );
endinterface

// File: rtl/ring_xbar3_switch_alloc.sv
// Switch allocator for the 3x3 ring crossbar: per-output round-robin arbitration
// with packet locking, zero-latency idle grant and held mux selects.
module ring_xbar3_switch_alloc #(
    parameter int p_ninputs = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     domain,
    ring_xbar3_switch_alloc_if.slave bus
);
    typedef enum logic {IDLE, LOCKED} mode_t;

    logic       val   [p_ninputs];
    logic [1:0] dest  [p_ninputs];
    logic       tail  [p_ninputs];
    logic       ordy  [p_ninputs];

    mode_t      mode  [p_ninputs];
    logic [1:0] owner [p_ninputs];
    logic [1:0] prio  [p_ninputs];
    logic [1:0] sel_q [p_ninputs];

    logic       gnt_v [p_ninputs];
    logic [1:0] gnt   [p_ninputs];
    logic       oval  [p_ninputs];
    logic [1:0] sel   [p_ninputs];
    logic       irdy  [p_ninputs];
    logic       xfer  [p_ninputs];

    // domain is a security label only; it never steers the datapath
    logic unused_domain;
    assign unused_domain = domain;

    function automatic logic [1:0] next_idx(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    assign val[0]  = bus.in0_val;   assign val[1]  = bus.in1_val;   assign val[2]  = bus.in2_val;
    assign dest[0] = bus.in0_dest;  assign dest[1] = bus.in1_dest;  assign dest[2] = bus.in2_dest;
    assign tail[0] = bus.in0_tail;  assign tail[1] = bus.in1_tail;  assign tail[2] = bus.in2_tail;
    assign ordy[0] = bus.out0_rdy;  assign ordy[1] = bus.out1_rdy;  assign ordy[2] = bus.out2_rdy;

    assign bus.in0_rdy  = irdy[0];  assign bus.in1_rdy  = irdy[1];  assign bus.in2_rdy  = irdy[2];
    assign bus.out0_val = oval[0];  assign bus.out1_val = oval[1];  assign bus.out2_val = oval[2];
    assign bus.sel0     = sel[0];   assign bus.sel1     = sel[1];   assign bus.sel2     = sel[2];

    // A locked output stays with its owner; an idle one scans from prio round the ring.
    always_comb begin
        logic [1:0] cand;
        cand = 2'd0;
        for (int j = 0; j < p_ninputs; j++) begin
            gnt_v[j] = 1'b0;
            gnt[j]   = 2'd0;
            if (mode[j] == LOCKED) begin
                gnt_v[j] = 1'b1;
                gnt[j]   = owner[j];
            end else begin
                cand = prio[j];
                for (int k = 0; k < p_ninputs; k++) begin
                    if (!gnt_v[j] && val[cand] && dest[cand] == 2'(j)) begin
                        gnt_v[j] = 1'b1;
                        gnt[j]   = cand;
                    end
                    cand = next_idx(cand);
                end
            end
            oval[j] = !reset && gnt_v[j] && val[gnt[j]];
            sel[j]  = reset ? 2'd0 : (gnt_v[j] ? gnt[j] : sel_q[j]);
            xfer[j] = oval[j] && ordy[j];
        end
    end

    always_comb begin
        for (int i = 0; i < p_ninputs; i++) begin
            irdy[i] = 1'b0;
            if (!reset && dest[i] != 2'd3)
                irdy[i] = gnt_v[dest[i]] && gnt[dest[i]] == 2'(i) && ordy[dest[i]];
        end
    end

    // A tail transfer releases the output and rotates priority past the grantee.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < p_ninputs; j++) begin
                mode[j]  <= IDLE;
                owner[j] <= 2'd0;
                prio[j]  <= 2'd0;
                sel_q[j] <= 2'd0;
            end
        end else begin
            for (int j = 0; j < p_ninputs; j++) begin
                if (xfer[j]) begin
                    sel_q[j] <= gnt[j];
                    if (tail[gnt[j]]) begin
                        mode[j] <= IDLE;
                        prio[j] <= next_idx(gnt[j]);
                    end else if (mode[j] == IDLE) begin
                        mode[j]  <= LOCKED;
                        owner[j] <= gnt[j];
                    end
                end
            end
        end
    end
endmodule
